// File: rtl/fp_div_sequencer.sv
// Issue/retire sequencer for the multi-cycle FP divider: accepts one FDIV, resolves rm,
// starts the divider, and holds the result for writeback; survives flushes of a running divide.
module fp_div_sequencer #(
  parameter int unsigned FLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  input  logic [2:0]      req_rm,
  input  logic [4:0]      req_rd,
  input  logic [2:0]      frm,
  output logic            div_start,
  output logic [FLEN-1:0] div_a,
  output logic [FLEN-1:0] div_b,
  output logic [2:0]      div_rm,
  input  logic            div_done,
  input  logic [FLEN-1:0] div_result,
  input  logic [4:0]      div_flags,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [FLEN-1:0] wb_result,
  output logic [4:0]      wb_flags,
  output logic [4:0]      wb_rd,
  output logic            wb_illegal,
  output logic [31:0]     perf_div_count
);

  localparam int unsigned RM_W   = 3;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                div_start_q, div_start_d;
  logic [FLEN-1:0]     div_a_q, div_a_d;
  logic [FLEN-1:0]     div_b_q, div_b_d;
  logic [RM_W-1:0]     div_rm_q, div_rm_d;
  logic                wb_valid_q, wb_valid_d;
  logic [FLEN-1:0]     wb_result_q, wb_result_d;
  logic [FLAG_W-1:0]   wb_flags_q, wb_flags_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                wb_illegal_q, wb_illegal_d;
  logic [CNT_W-1:0]    perf_q, perf_d;

  logic [RM_W-1:0]     rm_res;
  logic                rm_illegal;
  logic                accept;

  // Dynamic rounding mode resolution; 101/110/111 after resolution are reserved
  always_comb begin
    rm_res     = (req_rm == 3'b111) ? frm : req_rm;
    rm_illegal = rm_res[2] && (rm_res[1:0] != 2'b00);
  end

  assign req_ready = (state_q == S_IDLE) && !flush && reset_n;
  assign accept    = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; flush always wins, but a running divide must be drained
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = rm_illegal ? S_HOLD : S_START;
      S_START: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (div_done)   state_d = flush ? S_IDLE : S_HOLD;
        else if (flush) state_d = S_DRAIN;
      end
      S_HOLD:  if (flush || wb_ready) state_d = S_IDLE;
      S_DRAIN: if (div_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_rm_d     = div_rm_q;
    wb_result_d  = wb_result_q;
    wb_flags_d   = wb_flags_q;
    wb_rd_d      = wb_rd_q;
    wb_illegal_d = wb_illegal_q;
    perf_d       = perf_q;
    div_start_d  = (state_d == S_START);
    wb_valid_d   = (state_d == S_HOLD);

    if (accept) begin
      div_a_d      = req_a;
      div_b_d      = req_b;
      div_rm_d     = rm_res;
      wb_rd_d      = req_rd;
      wb_illegal_d = rm_illegal;
      wb_result_d  = '0;
      wb_flags_d   = '0;
    end

    if ((state_q == S_WAIT) && div_done && !flush) begin
      wb_result_d = div_result;
      wb_flags_d  = div_flags;
    end

    if ((state_q == S_HOLD) && wb_ready && !flush && !wb_illegal_q)
      perf_d = perf_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_start_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_rm_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_result_q  <= '0;
      wb_flags_q   <= '0;
      wb_rd_q      <= '0;
      wb_illegal_q <= 1'b0;
      perf_q       <= '0;
    end else begin
      div_start_q  <= div_start_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_rm_q     <= div_rm_d;
      wb_valid_q   <= wb_valid_d;
      wb_result_q  <= wb_result_d;
      wb_flags_q   <= wb_flags_d;
      wb_rd_q      <= wb_rd_d;
      wb_illegal_q <= wb_illegal_d;
      perf_q       <= perf_d;
    end
  end

  assign div_start      = div_start_q;
  assign div_a          = div_a_q;
  assign div_b          = div_b_q;
  assign div_rm         = div_rm_q;
  assign wb_valid       = wb_valid_q;
  assign wb_result      = wb_result_q;
  assign wb_flags       = wb_flags_q;
  assign wb_rd          = wb_rd_q;
  assign wb_illegal     = wb_illegal_q;
  assign perf_div_count = perf_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Bench for fp_div_sequencer: behavioural divider, request table with scoreboard queue,
// plus directed backpressure, flush and mid-operation reset sequences.
module tb_fp_div_sequencer;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_rm, frm;
  logic [4:0]  req_rd;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [2:0]  div_rm;
  logic        div_done;
  logic [31:0] div_result;
  logic [4:0]  div_flags;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_result;
  logic [4:0]  wb_flags, wb_rd;
  logic        wb_illegal;
  logic [31:0] perf_div_count;

  fp_div_sequencer #(.FLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_rd(req_rd), .frm(frm),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_rm(div_rm),
    .div_done(div_done), .div_result(div_result), .div_flags(div_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .wb_flags(wb_flags), .wb_rd(wb_rd), .wb_illegal(wb_illegal),
    .perf_div_count(perf_div_count)
  );

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  rm, frm, xrm;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t q[$];
  vec_t tbl[9];
  int   div_lat = 4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural divider: known quotients for the reference operands, a scrambled value otherwise
  function automatic logic [36:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] rm);
    if (a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
    if (a == 32'h3F800000 && b == 32'h40400000) return {32'h3EAAAAAB, 5'b00001};
    return {(a ^ {b[15:0], b[31:16]}) + 32'(rm), a[4:0] ^ b[9:5]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                              input logic [2:0] f, input logic [4:0] rd, input int lat,
                              input logic [2:0] xrm, input logic ill);
    vec_t v;
    v.a = a; v.b = b; v.rm = rm; v.frm = f; v.rd = rd; v.lat = lat;
    v.xrm = xrm; v.ill = ill;
    if (ill) begin v.res = '0; v.flg = '0; end
    else {v.res, v.flg} = div_ref(a, b, xrm);
    return v;
  endfunction

  // Divider model: cannot be aborted, samples operands/rm in the completion cycle
  int div_cnt;
  always @(posedge clk) begin
    if (!reset_n) begin
      div_cnt    <= 0;
      div_done   <= 1'b0;
      div_result <= '0;
      div_flags  <= '0;
    end else begin
      div_done   <= 1'b0;
      div_result <= $urandom();
      div_flags  <= 5'($urandom());
      if (div_cnt != 0) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 1) begin
          div_done <= 1'b1;
          {div_result, div_flags} <= div_ref(div_a, div_b, div_rm);
        end
      end else if (div_start) begin
        div_cnt <= div_lat;
      end
    end
  end

  // Monitor: timing, stability and scoreboard comparison at the falling edge
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;
  logic        in_div = 0, prev_start = 0, wb_was = 0;
  logic [31:0] sa, sb, s_res, exp_perf = 0;
  logic [2:0]  srm;
  logic [4:0]  s_flg, s_rd;
  logic        s_ill;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      q.delete();
      exp_perf   = 0;
      in_div     = 0;
      wb_was     = 0;
      prev_start = 0;
    end else begin
      check("perf_div_count", 64'(perf_div_count), 64'(exp_perf));
      if (req_valid && req_ready) acc_cyc = cyc;
      if (prev_start) check("start_one_cycle", 64'(div_start), 0);
      if (div_start) begin
        if (q.size() == 0) check("start_has_txn", 0, 1);
        else begin
          check("start_legal", 64'(q[0].ill), 0);
          check("start_time", 64'(cyc), 64'(acc_cyc + 1));
          check("div_a", 64'(div_a), 64'(q[0].a));
          check("div_b", 64'(div_b), 64'(q[0].b));
          check("div_rm", 64'(div_rm), 64'(q[0].xrm));
        end
        in_div = 1; sa = div_a; sb = div_b; srm = div_rm;
      end else if (in_div) begin
        check("div_stable", 64'({div_a, div_b, div_rm} == {sa, sb, srm}), 1);
        if (div_done) begin in_div = 0; done_cyc = cyc; end
      end
      if (wb_valid) begin
        check("req_ready_busy", 64'(req_ready), 0);
        if (!wb_was) begin
          if (q.size() == 0) check("wb_has_txn", 0, 1);
          else check("wb_valid_time", 64'(cyc), 64'(q[0].ill ? acc_cyc + 1 : done_cyc + 1));
          s_res = wb_result; s_flg = wb_flags; s_rd = wb_rd; s_ill = wb_illegal;
          wb_was = 1;
        end else begin
          check("wb_stable", 64'({wb_result, wb_flags, wb_rd, wb_illegal} ==
                                {s_res, s_flg, s_rd, s_ill}), 1);
        end
        if (flush || wb_ready) begin
          if (q.size() != 0) begin
            if (!flush) begin
              check("wb_result", 64'(wb_result), 64'(q[0].res));
              check("wb_flags", 64'(wb_flags), 64'(q[0].flg));
              check("wb_rd", 64'(wb_rd), 64'(q[0].rd));
              check("wb_illegal", 64'(wb_illegal), 64'(q[0].ill));
              if (!q[0].ill) exp_perf = exp_perf + 32'd1;
            end
            void'(q.pop_front());
          end
          wb_was = 0;
        end
      end else begin
        wb_was = 0;
        if (flush && q.size() != 0) void'(q.pop_front());
      end
      prev_start = div_start;
    end
  end

  task automatic issue(input vec_t v);
    int n = 0;
    @(posedge clk); #1;
    div_lat = v.lat;
    req_a = v.a; req_b = v.b; req_rm = v.rm; frm = v.frm; req_rd = v.rd;
    req_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!req_ready && n < 300);
    if (req_ready) q.push_back(v);
    else check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(req_ready && q.size() == 0) && n < 300);
    if (n >= 300) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic wait_wb(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!wb_valid && n < 300);
    if (!wb_valid) check({name, "_wb_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'(|{req_ready, div_start, div_a, div_b, div_rm, wb_valid, wb_result,
                       wb_flags, wb_rd, wb_illegal, perf_div_count}), 0);
  endtask

  initial begin
    int   nlegal = 0;
    int   n;
    vec_t v;
    logic [31:0] perf_before;
    reset_n = 1'b0; flush = 1'b0; req_valid = 1'b0; wb_ready = 1'b1;
    req_a = '0; req_b = '0; req_rm = '0; frm = '0; req_rd = '0;

    tbl[0] = mk(32'h40C00000, 32'h40000000, 3'd0, 3'd0, 5'd5,  4,  3'd0, 1'b0);
    tbl[1] = mk(32'h3F800000, 32'h40400000, 3'd7, 3'd3, 5'd7,  6,  3'd3, 1'b0);
    tbl[2] = mk(32'h12345678, 32'h9ABCDEF0, 3'd5, 3'd0, 5'd1,  3,  3'd5, 1'b1);
    tbl[3] = mk(32'h11111111, 32'h22222222, 3'd7, 3'd6, 5'd2,  3,  3'd6, 1'b1);
    tbl[4] = mk(32'h33333333, 32'h44444444, 3'd6, 3'd1, 5'd3,  3,  3'd6, 1'b1);
    tbl[5] = mk(32'hCAFEF00D, 32'h0BADBEEF, 3'd1, 3'd7, 5'd31, 1,  3'd1, 1'b0);
    tbl[6] = mk(32'h55AA55AA, 32'h0F0F0F0F, 3'd4, 3'd2, 5'd8,  10, 3'd4, 1'b0);
    tbl[7] = mk(32'h7F7FFFFF, 32'h00800000, 3'd7, 3'd2, 5'd9,  2,  3'd2, 1'b0);
    tbl[8] = mk(32'h01020304, 32'h05060708, 3'd7, 3'd7, 5'd10, 3,  3'd7, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i]);
      wait_idle("vec");
      if (!tbl[i].ill) nlegal++;
      check("perf_after_vec", 64'(perf_div_count), 64'(nlegal));
    end

    // Backpressure with a second request already waiting
    wb_ready = 1'b0;
    issue(tbl[5]);
    wait_wb("bp");
    @(posedge clk); #1;
    div_lat = tbl[6].lat;
    req_a = tbl[6].a; req_b = tbl[6].b; req_rm = tbl[6].rm; frm = tbl[6].frm;
    req_rd = tbl[6].rd; req_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 0);
      check("bp_wb_valid", 64'(wb_valid), 1);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_in_hold", 64'(req_ready), 0);
    @(negedge clk);
    check("bp_accept_next", 64'(req_ready), 1);
    if (req_ready) q.push_back(tbl[6]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle("bp");

    // Flush while the divider is running: drain, no writeback
    v = tbl[6]; v.lat = 8;
    issue(v);
    @(negedge clk);
    check("fw_start", 64'(div_start), 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!div_done && n < 50);
    check("fw_done_seen", 64'(div_done), 1);
    check("fw_drain_busy", 64'(req_ready), 0);
    check("fw_no_wb", 64'(wb_valid), 0);
    @(negedge clk);
    check("fw_ready_after_done", 64'(req_ready), 1);

    // Flush in the same cycle as div_done
    v = tbl[7]; v.lat = 5;
    issue(v);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!div_done && n < 50);
    check("fc_done_seen", 64'(div_done), 1);
    flush = 1'b1;
    @(negedge clk);
    check("fc_no_wb", 64'(wb_valid), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fc_idle", 64'(req_ready), 1);
    check("fc_no_wb_after", 64'(wb_valid), 0);

    // Flush in HOLD together with wb_ready: flush wins, no count
    wb_ready = 1'b0;
    issue(tbl[0]);
    wait_wb("fh");
    perf_before = perf_div_count;
    @(posedge clk); #1;
    flush = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fh_wb_drop", 64'(wb_valid), 0);
    check("fh_idle", 64'(req_ready), 1);
    check("fh_no_count", 64'(perf_div_count), 64'(perf_before));

    // Reset in WAIT, then a fresh request
    v = tbl[1]; v.lat = 12;
    issue(v);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_req_ready", 64'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("rst_mid_outputs");
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(tbl[0]);
    wait_idle("post_rst");
    check("post_rst_perf", 64'(perf_div_count), 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_div_sequencer.md
# fp_div_sequencer

Issue/retire sequencer between FPU execute and the multi-cycle floating-point divider. It accepts one FDIV request from the pipeline with a valid/ready handshake and resolves the dynamic rounding mode. It drives the divider's start pulse, holding operands and rounding mode stable until the divider reports done, then captures result and exception flags for writeback through a second valid/ready handshake. It also handles pipeline flushes while the divider, which cannot be aborted, is still running.

## Interface
Parameters:
- FLEN, 32, operand/result width (32 or 64)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- flush  in  1  kill the in-flight request
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_a  in  FLEN  dividend
- req_b  in  FLEN  divisor
- req_rm  in  3  instruction rm field
- req_rd  in  5  destination register
- frm  in  3  fcsr.frm, used when req_rm = 3'b111
- div_start  out  1  one-cycle start pulse to divider
- div_a, div_b  out  FLEN  operands to divider
- div_rm  out  3  resolved rounding mode to divider
- div_done  in  1  divider completion pulse
- div_result  in  FLEN  divider result
- div_flags  in  5  {nv,dz,of,uf,nx} from divider
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_result  out  FLEN  captured result
- wb_flags  out  5  captured {nv,dz,of,uf,nx}
- wb_rd  out  5  captured destination
- wb_illegal  out  1  request had an invalid rounding mode
- perf_div_count  out  32  completed legal divisions

## Operation
- States: IDLE, START, WAIT, HOLD, DRAIN.
- req_ready = (state==IDLE) && !flush && reset_n.
- **IDLE:** on req_valid && req_ready, latch a, b, rd and resolved rm (req_rm, or frm if req_rm==111).
  - Resolved rm 101/110/111 is illegal. Go to HOLD with wb_illegal=1, wb_result=0, wb_flags=0. Divider is not started.
  - Otherwise go to START.
- **START:** div_start=1 for exactly this cycle. Next state is WAIT, or DRAIN if flush.
- **WAIT:** on div_done, capture div_result/div_flags into wb_result/wb_flags and go to HOLD.
  - flush without div_done goes to DRAIN.
  - flush with div_done in the same cycle discards the result and goes to IDLE.
- **HOLD:** wb_valid=1, and wb_* stay stable.
  - On wb_ready: go to IDLE, and increment perf_div_count if !wb_illegal.
  - flush: go to IDLE, drop wb_valid, no count.
  - flush has priority over wb_ready.
- **DRAIN:** wait for div_done, discard its result, go to IDLE. wb_valid stays 0. flush in DRAIN has no effect.
- div_a/div_b/div_rm are registered and stay constant from START through the cycle div_done is seen. The divider samples operands after start and rm late in its operation.
- div_done is ignored in IDLE, START and HOLD.
- perf_div_count wraps modulo 2^32.

## Timing
- Reset (reset_n low at a clk edge):
  - state=IDLE.
  - All outputs 0, including req_ready while reset_n is low.
  - perf_div_count=0.
  - Reset mid-operation abandons everything. The bench must also reset the divider.
- Accept at edge 0, div_start high in cycle 1.
- If div_done is high in cycle N, wb_valid is high from cycle N+1.
- Illegal-rm request: wb_valid high in the cycle after accept.
- One request in flight at a time. req_ready is 0 from the accept edge until the cycle after the HOLD exit handshake or the DRAIN completion.
- Minimum issue interval = divider latency + 3 cycles with wb_ready held high.

## Test plan
- **Normal divide:**
  - Stimulus: a=0x40C00000 (6.0), b=0x40000000 (2.0), rm=000, rd=5.
  - Required: one div_start pulse and div_rm=000; wb_result=0x40400000, wb_flags=0, wb_rd=5; perf_div_count=1.
- **Dynamic rm and stability:**
  - Stimulus: req_rm=111, frm=011, a=0x3F800000, b=0x40400000.
  - Required: div_rm=011 held stable until div_done; wb_result=0x3EAAAAAB with nx=1.
- **Illegal rm:**
  - Stimulus: req_rm=101.
  - Required: no div_start; wb_valid the next cycle with wb_illegal=1; perf_div_count unchanged after handshake.
- **Backpressure:**
  - Stimulus: wb_ready low for 10 cycles after result, with req_valid held high.
  - Required: wb_* stable; req_ready=0 throughout; second request accepted the cycle after the wb handshake.
- **Flush cases:**
  - Flush in WAIT: DRAIN, no wb_valid, req_ready returns after the divider's done.
  - Flush coincident with div_done: go directly to IDLE.
  - Flush in HOLD: wb_valid drops the next cycle, no count.
- **Reset:**
  - Stimulus: reset_n low in WAIT.
  - Required: all outputs 0 the next cycle; new request accepted after reset release.
